// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its neighbours: the byte-wide
// RAM/IO port, the instruction-fetch request channel and the load/store
// buffer request channel. The arbiter uses the master view, and the
// environment (RAM, fetcher, LSB) uses the slave view.
interface mem_arbiter_if;
    // RAM / IO port
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    // Pipeline flush
    logic        _clear;

    // Instruction fetch channel
    logic        _if_ready;
    logic [31:0] _if_addr;
    logic        _if_recive;
    logic        _if_mem_ready;
    logic [31:0] _if_data;

    // Load/store buffer channel
    logic        _lsb_mem_ready;
    logic [1:0]  _work_type;
    logic        _r_nw_in;
    logic [31:0] _addr;
    logic [31:0] _data_in;
    logic        _recive;
    logic        _mem_lsb_ready;
    logic [31:0] _data_out;

    modport master (
        input  mem_din, io_buffer_full, _clear,
        input  _if_ready, _if_addr,
        input  _lsb_mem_ready, _work_type, _r_nw_in, _addr, _data_in,
        output mem_dout, mem_a, mem_wr,
        output _if_recive, _if_mem_ready, _if_data,
        output _recive, _mem_lsb_ready, _data_out
    );

    modport slave (
        output mem_din, io_buffer_full, _clear,
        output _if_ready, _if_addr,
        output _lsb_mem_ready, _work_type, _r_nw_in, _addr, _data_in,
        input  mem_dout, mem_a, mem_wr,
        input  _if_recive, _if_mem_ready, _if_data,
        input  _recive, _mem_lsb_ready, _data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares the single byte-wide RAM/IO port between the
// instruction fetcher (32-bit reads) and the load/store buffer (1/2/4-byte
// loads and stores). Multi-byte accesses run as consecutive byte cycles;
// read bytes are packed little-endian into a 32-bit shift register.
// A flush aborts reads, but a store that has started always completes.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE     = 32'h0003_0000,
    parameter logic        RESET_GRANT = 1'b1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Requester identities; last_grant uses the same encoding.
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSB = 1'b1;

    state_e      state_q,      state_d;
    logic [31:0] addr_q,       addr_d;
    logic [2:0]  n_q,          n_d;        // bytes in this access: 1, 2 or 4
    logic [2:0]  k_q,          k_d;        // current byte index
    logic        owner_q,      owner_d;
    logic [31:0] sh_q,         sh_d;       // read shift register
    logic [31:0] wdata_q,      wdata_d;    // latched store data
    logic        last_grant_q, last_grant_d;
    logic        orphan_q,     orphan_d;   // store survived a flush; no done pulse
    logic        if_done_q,    if_done_d;
    logic        lsb_done_q,   lsb_done_d;
    logic [31:0] if_data_q,    if_data_d;
    logic [31:0] lsb_data_q,   lsb_data_d;

    logic        grant_if;
    logic        grant_lsb;
    logic        io_stall;
    logic [31:0] cur_addr;

    // Access size in bytes; the unused encoding 2'b10 is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] wt);
        case (wt)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // An IO write stalls in place while the IO buffer is full.
    assign io_stall = (addr_q >= IO_BASE) && bus.io_buffer_full;
    // Byte address of the current cycle; wraps naturally past 32'hFFFF_FFFF.
    assign cur_addr = addr_q + {29'd0, k_q};

    // State register: synchronous reset, frozen entirely while rdy_in is low.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of all the others.
        if (rst_in) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            n_q          <= '0;
            k_q          <= '0;
            owner_q      <= OWN_IF;
            sh_q         <= '0;
            wdata_q      <= '0;
            last_grant_q <= RESET_GRANT;
            orphan_q     <= 1'b0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_data_q    <= '0;
            lsb_data_q   <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            n_q          <= n_d;
            k_q          <= k_d;
            owner_q      <= owner_d;
            sh_q         <= sh_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            orphan_q     <= orphan_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_data_q    <= if_data_d;
            lsb_data_q   <= lsb_data_d;
        end
    end

    // Next-state logic: arbitration, byte sequencing, flush handling.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        n_d          = n_q;
        k_d          = k_q;
        owner_d      = owner_q;
        sh_d         = sh_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        orphan_d     = orphan_q;
        if_done_d    = 1'b0;
        lsb_done_d   = 1'b0;
        if_data_d    = if_data_q;
        lsb_data_d   = lsb_data_q;
        grant_if     = 1'b0;
        grant_lsb    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                orphan_d = 1'b0;
                if (!bus._clear) begin
                    // On a tie the requester that was not granted last wins.
                    if (bus._if_ready &&
                        (!bus._lsb_mem_ready || last_grant_q == OWN_LSB)) begin
                        grant_if = 1'b1;
                    end else if (bus._lsb_mem_ready) begin
                        grant_lsb = 1'b1;
                    end
                end

                if (grant_if) begin
                    owner_d      = OWN_IF;
                    last_grant_d = OWN_IF;
                    addr_d       = bus._if_addr;
                    n_d          = 3'd4;
                    k_d          = 3'd0;
                    sh_d         = '0;
                    state_d      = ST_READ;
                end else if (grant_lsb) begin
                    owner_d      = OWN_LSB;
                    last_grant_d = OWN_LSB;
                    addr_d       = bus._addr;
                    n_d          = size_bytes(bus._work_type);
                    k_d          = 3'd0;
                    sh_d         = '0;
                    wdata_d      = bus._data_in;
                    state_d      = bus._r_nw_in ? ST_WRITE : ST_READ;
                end
            end

            ST_READ: begin
                if (bus._clear) begin
                    // Speculative read: drop it with no completion.
                    state_d = ST_IDLE;
                    k_d     = 3'd0;
                end else begin
                    // The byte for index k-1 arrives while index k is current.
                    if (k_q != 3'd0) begin
                        sh_d = {bus.mem_din, sh_q[31:8]};
                    end
                    if (k_q == n_q) begin
                        state_d = ST_IDLE;
                        k_d     = 3'd0;
                        if (owner_q == OWN_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = sh_d;
                        end else begin
                            lsb_done_d = 1'b1;
                            lsb_data_d = sh_d;
                        end
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end

            ST_WRITE: begin
                // A committed store keeps going through a flush, silently.
                if (bus._clear) begin
                    orphan_d = 1'b1;
                end
                if (!io_stall) begin
                    if (k_q == n_q - 3'd1) begin
                        state_d    = ST_IDLE;
                        k_d        = 3'd0;
                        lsb_done_d = !(orphan_q || bus._clear);
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                k_d     = 3'd0;
            end
        endcase
    end

    // Output decode: memory port from registers, pulses gated by rdy_in.
    always_comb begin
        bus.mem_a    = '0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = '0;

        case (state_q)
            ST_READ: begin
                if (k_q != n_q) begin
                    bus.mem_a = cur_addr;
                end
            end
            ST_WRITE: begin
                bus.mem_a  = cur_addr;
                bus.mem_wr = rdy_in && !io_stall;
                case (k_q[1:0])
                    2'd0:    bus.mem_dout = wdata_q[7:0];
                    2'd1:    bus.mem_dout = wdata_q[15:8];
                    2'd2:    bus.mem_dout = wdata_q[23:16];
                    default: bus.mem_dout = wdata_q[31:24];
                endcase
            end
            default: ;
        endcase

        bus._if_recive     = grant_if  && rdy_in && !rst_in;
        bus._recive        = grant_lsb && rdy_in && !rst_in;
        bus._if_mem_ready  = if_done_q  && rdy_in && !bus._clear;
        bus._mem_lsb_ready = lsb_done_q && rdy_in && !bus._clear;
        bus._if_data       = if_data_q;
        bus._data_out      = lsb_data_q;
    end

    // Structural invariants of the arbiter.
    a_one_accept : assert property (@(posedge clk_in) disable iff (rst_in)
        !(bus._recive && bus._if_recive));
    a_one_done : assert property (@(posedge clk_in) disable iff (rst_in)
        !(if_done_q && lsb_done_q));
    a_wr_in_write : assert property (@(posedge clk_in) disable iff (rst_in)
        (state_q != ST_WRITE) |-> !bus.mem_wr);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(
        .IO_BASE    (32'h0003_0000),
        .RESET_GRANT(1'b1)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .bus   (bus)
    );

    // Byte RAM model: read data appears one cycle after the address.
    bit [7:0] ram [bit [31:0]];

    always @(posedge clk) begin
        bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus._if_ready      = 1'b0;
        bus._lsb_mem_ready = 1'b0;
        bus._clear         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic lsb_req(input logic [1:0] wt, input bit st, input logic [31:0] a, input logic [31:0] d);
        bus._lsb_mem_ready = 1'b1;
        bus._work_type     = wt;
        bus._r_nw_in       = st;
        bus._addr          = a;
        bus._data_in       = d;
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram[a + 32'd3], ram[a + 32'd2], ram[a + 32'd1], ram[a]};
    endfunction

    typedef struct {
        string       name;
        bit          is_if;
        logic [1:0]  wt;
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rbytes;   // RAM preset, little-endian from addr
        int          nbytes;
        int          lat;      // cycles from accept to done pulse
        logic [31:0] exp;      // load result, or RAM word after a store
    } vec_t;

    vec_t vecs [9];

    // One isolated request: accept pulse, per-byte bus trace, latency, result.
    task automatic run_vec(input vec_t v);
        bit          seen;
        int          lat;
        logic [31:0] res;
        logic [31:0] word;
        for (int i = 0; i < 4; i++) ram[v.addr + 32'(i)] = v.rbytes[8*i +: 8];
        if (v.is_if) begin
            bus._if_ready = 1'b1;
            bus._if_addr  = v.addr;
        end else begin
            lsb_req(v.wt, v.st, v.addr, v.wdata);
        end
        @(negedge clk);
        check({v.name, "/recive"}, v.is_if ? 32'(bus._if_recive) : 32'(bus._recive), 32'd1);
        step();
        idle_inputs();
        seen = 1'b0;
        lat  = 0;
        res  = '0;
        for (int c = 1; c <= 16 && !seen; c++) begin
            @(negedge clk);
            if (c <= v.nbytes) begin
                check({v.name, "/mem_a"}, bus.mem_a, v.addr + 32'(c - 1));
                check({v.name, "/mem_wr"}, 32'(bus.mem_wr), 32'(v.st));
                if (v.st) check({v.name, "/mem_dout"}, 32'(bus.mem_dout), 32'(8'(v.wdata >> (8*(c - 1)))));
            end
            if (v.is_if ? bus._if_mem_ready : bus._mem_lsb_ready) begin
                seen = 1'b1;
                lat  = c;
                res  = v.is_if ? bus._if_data : bus._data_out;
            end
            step();
        end
        check({v.name, "/latency"}, 32'(lat), 32'(v.lat));
        word = v.st ? ram_word(v.addr) : res;
        check({v.name, "/data"}, word, v.exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          ng;
        int          nwr;
        logic [3:0]  grants;

        rdy                = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus._if_addr       = '0;
        bus._work_type     = '0;
        bus._r_nw_in       = 1'b0;
        bus._addr          = '0;
        bus._data_in       = '0;
        idle_inputs();

        vecs[0] = '{"fetch",      1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         32'h4433_2211, 4, 6, 32'h4433_2211};
        vecs[1] = '{"lb",         1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_0080, 1, 3, 32'h8000_0000};
        vecs[2] = '{"lhu",        1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_7F80, 2, 4, 32'h7F80_0000};
        vecs[3] = '{"lw",         1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0,         32'h0403_0201, 4, 6, 32'h0403_0201};
        vecs[4] = '{"lw_t10",     1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0,         32'h0807_0605, 4, 6, 32'h0807_0605};
        vecs[5] = '{"sw",         1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 4, 5, 32'hDEAD_BEEF};
        vecs[6] = '{"sh",         1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'hFFFF_FFFF, 2, 3, 32'hFFFF_1234};
        vecs[7] = '{"sb",         1'b0, 2'b00, 1'b1, 32'h0000_0030, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 2, 32'hFFFF_FFA5};
        vecs[8] = '{"fetch_wrap", 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA, 4, 6, 32'hDDCC_BBAA};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst/mem_a",          bus.mem_a,              32'h0);
        check("rst/mem_wr",         32'(bus.mem_wr),        32'h0);
        check("rst/mem_dout",       32'(bus.mem_dout),      32'h0);
        check("rst/if_data",        bus._if_data,           32'h0);
        check("rst/data_out",       bus._data_out,          32'h0);
        check("rst/if_mem_ready",   32'(bus._if_mem_ready), 32'h0);
        check("rst/mem_lsb_ready",  32'(bus._mem_lsb_ready),32'h0);
        check("rst/recive",         32'(bus._recive),       32'h0);
        step();

        // Table of isolated transactions
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Both requesters held: grants alternate, each accept in a done cycle
        do_reset();
        bus._if_ready = 1'b1;
        bus._if_addr  = 32'h0000_0100;
        lsb_req(2'b00, 1'b0, 32'h0000_0200, 32'h0);
        ng     = 0;
        grants = '0;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            @(negedge clk);
            if (bus._if_recive || bus._recive) begin
                check("arb/one_grant", 32'(bus._if_recive && bus._recive), 32'h0);
                if (ng > 0) check("arb/b2b", 32'(bus._if_mem_ready || bus._mem_lsb_ready), 32'h1);
                grants[ng] = bus._recive;
                ng++;
            end
            step();
        end
        idle_inputs();
        check("arb/count", 32'(ng), 32'd4);
        check("arb/order", 32'(grants), 32'b1010);
        repeat (10) step();

        // IO store stalled by a full IO buffer for 3 cycles
        ram[32'h0003_0000] = 8'h00;
        lsb_req(2'b00, 1'b1, 32'h0003_0000, 32'h0000_0041);
        @(negedge clk);
        check("io/recive", 32'(bus._recive), 32'h1);
        step();
        idle_inputs();
        bus.io_buffer_full = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("io/stall_wr", 32'(bus.mem_wr), 32'h0);
            step();
        end
        bus.io_buffer_full = 1'b0;
        @(negedge clk);
        check("io/wr",    32'(bus.mem_wr),   32'h1);
        check("io/dout",  32'(bus.mem_dout), 32'h41);
        check("io/mem_a", bus.mem_a,         32'h0003_0000);
        step();
        @(negedge clk);
        check("io/done", 32'(bus._mem_lsb_ready), 32'h1);
        check("io/ram",  32'(ram[32'h0003_0000]), 32'h41);
        step();

        // Flush during a fetch aborts it
        bus._if_ready = 1'b1;
        bus._if_addr  = 32'h0000_0300;
        @(negedge clk);
        check("clr_if/recive", 32'(bus._if_recive), 32'h1);
        step();
        idle_inputs();
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus._clear = (c == 2);
            @(negedge clk);
            if (c == 3) check("clr_if/idle_mem_a", bus.mem_a, 32'h0);
            if (bus._if_mem_ready) seen = 1'b1;
            step();
        end
        bus._clear = 1'b0;
        check("clr_if/no_done", 32'(seen), 32'h0);
        check("clr_if/data_hold", bus._if_data, 32'h4433_2211);

        // Flush during a store: all bytes written, completion suppressed
        for (int i = 0; i < 4; i++) ram[32'h40 + 32'(i)] = 8'h00;
        lsb_req(2'b11, 1'b1, 32'h0000_0040, 32'h1122_3344);
        @(negedge clk);
        check("clr_sw/recive", 32'(bus._recive), 32'h1);
        step();
        idle_inputs();
        nwr  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            bus._clear = (c == 2);
            @(negedge clk);
            if (bus.mem_wr) nwr++;
            if (bus._mem_lsb_ready) seen = 1'b1;
            step();
        end
        bus._clear = 1'b0;
        check("clr_sw/writes",  32'(nwr),  32'd4);
        check("clr_sw/no_done", 32'(seen), 32'h0);
        check("clr_sw/ram",     ram_word(32'h40), 32'h1122_3344);

        // Flush while idle blocks the accept
        bus._if_ready = 1'b1;
        bus._clear    = 1'b1;
        @(negedge clk);
        check("clr_idle/no_accept", 32'(bus._if_recive), 32'h0);
        step();
        idle_inputs();
        step();

        // rdy_in low freezes a store and forces mem_wr low
        ram[32'h50] = 8'h00;
        lsb_req(2'b00, 1'b1, 32'h0000_0050, 32'h0000_005A);
        @(negedge clk);
        check("rdy/recive", 32'(bus._recive), 32'h1);
        step();
        idle_inputs();
        rdy = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("rdy/frozen_wr",   32'(bus.mem_wr),         32'h0);
            check("rdy/frozen_done", 32'(bus._mem_lsb_ready), 32'h0);
            step();
        end
        rdy = 1'b1;
        @(negedge clk);
        check("rdy/wr",   32'(bus.mem_wr),   32'h1);
        check("rdy/dout", 32'(bus.mem_dout), 32'h5A);
        step();
        @(negedge clk);
        check("rdy/done", 32'(bus._mem_lsb_ready), 32'h1);
        step();

        // Reset in the middle of a store abandons the remaining bytes
        for (int i = 0; i < 4; i++) ram[32'h60 + 32'(i)] = 8'h00;
        lsb_req(2'b11, 1'b1, 32'h0000_0060, 32'hCAFE_BABE);
        @(negedge clk);
        check("rst_mid/recive", 32'(bus._recive), 32'h1);
        step();
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid/mem_wr",   32'(bus.mem_wr), 32'h0);
        check("rst_mid/mem_a",    bus.mem_a,       32'h0);
        check("rst_mid/data_out", bus._data_out,   32'h0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus._mem_lsb_ready) seen = 1'b1;
            step();
        end
        check("rst_mid/no_done", 32'(seen), 32'h0);
        check("rst_mid/ram",     ram_word(32'h60), 32'h0000_BABE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
